// File: rtl/i2s_frame_scheduler_if.sv
// Stream bundle for the frame scheduler: I2S RX in, engine request/result, I2S TX out.
// The master modport is the scheduler's view; slave is the surrounding system's view.
interface i2s_frame_scheduler_if #(
  parameter int DATA_W = 24
);
  logic [31:0]       rx_axis_s_data;
  logic              rx_axis_s_valid;
  logic              rx_axis_s_ready;
  logic              rx_axis_s_last;

  logic [DATA_W-1:0] proc_m_data;
  logic              proc_m_chan;
  logic              proc_m_valid;
  logic              proc_m_ready;

  logic [DATA_W-1:0] proc_s_data;
  logic              proc_s_valid;
  logic              proc_s_ready;

  logic [31:0]       tx_axis_m_data;
  logic              tx_axis_m_valid;
  logic              tx_axis_m_ready;
  logic              tx_axis_m_last;

  modport master (
    input  rx_axis_s_data, rx_axis_s_valid, rx_axis_s_last,
    output rx_axis_s_ready,
    output proc_m_data, proc_m_chan, proc_m_valid,
    input  proc_m_ready,
    input  proc_s_data, proc_s_valid,
    output proc_s_ready,
    output tx_axis_m_data, tx_axis_m_valid, tx_axis_m_last,
    input  tx_axis_m_ready
  );

  modport slave (
    output rx_axis_s_data, rx_axis_s_valid, rx_axis_s_last,
    input  rx_axis_s_ready,
    input  proc_m_data, proc_m_chan, proc_m_valid,
    output proc_m_ready,
    output proc_s_data, proc_s_valid,
    input  proc_s_ready,
    input  tx_axis_m_data, tx_axis_m_valid, tx_axis_m_last,
    output tx_axis_m_ready
  );
endinterface

// File: rtl/i2s_frame_scheduler.sv
// Stereo frame scheduler: buffers one RX frame, runs L then R through a shared mono
// engine (or bypasses it), then emits L then R on I2S TX. Counts overruns and timeouts.
module i2s_frame_scheduler #(
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 512,
  parameter int CNT_W   = 16
) (
  input  logic                axis_clk,
  input  logic                axis_resetn,
  i2s_frame_scheduler_if.master bus,
  input  logic                bypass,
  output logic                frame_done,
  output logic [CNT_W-1:0]    overrun_cnt,
  output logic [CNT_W-1:0]    timeout_cnt
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SEND_L, WAIT_L, SEND_R, WAIT_R, TX_L, TX_R} state_t;

  state_t            state_reg;
  logic              ready_reg;
  logic              expect_r_reg;
  logic              full_reg;
  logic [DATA_W-1:0] l_pend_reg, buf_l_reg, buf_r_reg;
  logic [DATA_W-1:0] work_l_reg, work_r_reg;
  logic [TMO_W-1:0]  tmo_reg;
  logic [DATA_W-1:0] pm_data_reg;
  logic              pm_chan_reg, pm_valid_reg;
  logic [DATA_W-1:0] tx_data_reg;
  logic              tx_valid_reg, tx_last_reg;
  logic              frame_done_reg;
  logic [CNT_W-1:0]  overrun_reg, timeout_reg;

  logic              rx_fire, frame_complete, launch, tmo_expired;
  logic [DATA_W-1:0] rx_sample;
  logic              unused_rx_bits;

  assign rx_fire        = bus.rx_axis_s_valid & ready_reg;
  assign rx_sample      = bus.rx_axis_s_data[DATA_W-1:0];
  assign frame_complete = rx_fire & bus.rx_axis_s_last & expect_r_reg;
  assign launch         = (state_reg == IDLE) & full_reg;
  assign tmo_expired    = (tmo_reg == TMO_LAST);
  assign unused_rx_bits = ^bus.rx_axis_s_data[31:DATA_W];

  // L beats land in a pending register so a frame already in the buffer is never
  // corrupted by the start of a frame that may end up dropped.
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      ready_reg    <= 1'b0;
      expect_r_reg <= 1'b0;
      full_reg     <= 1'b0;
      l_pend_reg   <= '0;
      buf_l_reg    <= '0;
      buf_r_reg    <= '0;
      overrun_reg  <= '0;
    end else begin
      ready_reg <= 1'b1;
      if (rx_fire) begin
        if (!bus.rx_axis_s_last) begin
          l_pend_reg   <= rx_sample;
          expect_r_reg <= 1'b1;
        end else if (expect_r_reg) begin
          expect_r_reg <= 1'b0;
        end
      end
      if (frame_complete && (!full_reg || launch)) begin
        buf_l_reg <= l_pend_reg;
        buf_r_reg <= rx_sample;
        full_reg  <= 1'b1;
      end else begin
        if (launch) full_reg <= 1'b0;
        if (frame_complete && overrun_reg != CNT_MAX) overrun_reg <= overrun_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_reg      <= IDLE;
      work_l_reg     <= '0;
      work_r_reg     <= '0;
      tmo_reg        <= '0;
      pm_data_reg    <= '0;
      pm_chan_reg    <= 1'b0;
      pm_valid_reg   <= 1'b0;
      tx_data_reg    <= '0;
      tx_valid_reg   <= 1'b0;
      tx_last_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      timeout_reg    <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (full_reg) begin
            work_l_reg <= buf_l_reg;
            work_r_reg <= buf_r_reg;
            if (bypass) begin
              state_reg <= TX_L;
            end else begin
              pm_data_reg  <= buf_l_reg;
              pm_chan_reg  <= 1'b0;
              pm_valid_reg <= 1'b1;
              state_reg    <= SEND_L;
            end
          end
        end
        SEND_L, SEND_R: begin
          if (bus.proc_m_ready) begin
            pm_valid_reg <= 1'b0;
            tmo_reg      <= '0;
            state_reg    <= (state_reg == SEND_L) ? WAIT_L : WAIT_R;
          end
        end
        WAIT_L, WAIT_R: begin
          if (bus.proc_s_valid || tmo_expired) begin
            if (!bus.proc_s_valid && timeout_reg != CNT_MAX) timeout_reg <= timeout_reg + 1'b1;
            if (state_reg == WAIT_L) begin
              if (bus.proc_s_valid) work_l_reg <= bus.proc_s_data;
              pm_data_reg  <= work_r_reg;
              pm_chan_reg  <= 1'b1;
              pm_valid_reg <= 1'b1;
              state_reg    <= SEND_R;
            end else begin
              if (bus.proc_s_valid) work_r_reg <= bus.proc_s_data;
              state_reg <= TX_L;
            end
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        TX_L: begin
          // One cycle to load the output register from the work registers.
          if (!tx_valid_reg) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= work_l_reg;
            tx_last_reg  <= 1'b0;
          end else if (bus.tx_axis_m_ready) begin
            tx_data_reg <= work_r_reg;
            tx_last_reg <= 1'b1;
            state_reg   <= TX_R;
          end
        end
        TX_R: begin
          if (bus.tx_axis_m_ready) begin
            tx_valid_reg   <= 1'b0;
            tx_last_reg    <= 1'b0;
            frame_done_reg <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rx_axis_s_ready = ready_reg;
  assign bus.proc_s_ready    = ready_reg;
  assign bus.proc_m_data     = pm_data_reg;
  assign bus.proc_m_chan     = pm_chan_reg;
  assign bus.proc_m_valid    = pm_valid_reg;
  assign bus.tx_axis_m_data  = {{(32-DATA_W){1'b0}}, tx_data_reg};
  assign bus.tx_axis_m_valid = tx_valid_reg;
  assign bus.tx_axis_m_last  = tx_last_reg;
  assign frame_done          = frame_done_reg;
  assign overrun_cnt         = overrun_reg;
  assign timeout_cnt         = timeout_reg;
endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Bench for i2s_frame_scheduler: directed scenarios plus randomized frames checked
// against a frame-level reference (expected sample = input, or inverted if processed).
module tb_i2s_frame_scheduler;
  localparam int DATA_W  = 24;
  localparam int TIMEOUT = 512;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bypass = 1'b0;
  logic frame_done;
  logic [CNT_W-1:0] overrun_cnt, timeout_cnt;

  i2s_frame_scheduler_if #(.DATA_W(DATA_W)) bus();

  i2s_frame_scheduler #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .axis_clk    (clk),
    .axis_resetn (rst_n),
    .bus         (bus),
    .bypass      (bypass),
    .frame_done  (frame_done),
    .overrun_cnt (overrun_cnt),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] data; logic last;} beat_t;
  typedef struct {logic [DATA_W-1:0] data; logic chan;} req_t;
  typedef struct {bit respond; int lat;} plan_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int rise_cyc = 0;
  beat_t tx_q[$];
  req_t  req_log[$];
  req_t  eng_q[$];
  plan_t plan_q[$];
  logic  tx_hold = 1'b0, tx_rand = 1'b0, m_rand = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_sample(input logic [DATA_W-1:0] s, input bit byp,
                                                   input bit resp);
    return (byp || !resp) ? s : ~s;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: observes handshakes away from the active edge.
  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_beat  = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall)
        check_value("tx_stable", {6'b0, bus.tx_axis_m_valid, bus.tx_axis_m_last,
                                  bus.tx_axis_m_data[DATA_W-1:0]}, prev_beat);
      prev_stall = bus.tx_axis_m_valid && !bus.tx_axis_m_ready;
      prev_beat  = {6'b0, bus.tx_axis_m_valid, bus.tx_axis_m_last, bus.tx_axis_m_data[DATA_W-1:0]};
      if (bus.tx_axis_m_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = bus.tx_axis_m_valid;
      if (bus.tx_axis_m_valid && bus.tx_axis_m_ready) begin
        tx_q.push_back('{bus.tx_axis_m_data, bus.tx_axis_m_last});
        $display("tx beat data=0x%06h last=%0d cyc=%0d", bus.tx_axis_m_data, bus.tx_axis_m_last, cyc);
      end
      if (bus.proc_m_valid && bus.proc_m_ready) begin
        req_log.push_back('{bus.proc_m_data, bus.proc_m_chan});
        eng_q.push_back('{bus.proc_m_data, bus.proc_m_chan});
      end
      if (frame_done) fd_cnt++;
    end
  end

  // Sink readiness and the invert engine model.
  bit                resp_active = 1'b0;
  int                resp_wait = 0;
  logic [DATA_W-1:0] resp_data = '0;
  req_t              eng_req;
  plan_t             eng_plan;
  initial begin
    bus.proc_s_valid = 1'b0;
    bus.proc_s_data  = '0;
    bus.proc_m_ready = 1'b0;
    bus.tx_axis_m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_axis_m_ready = tx_hold ? 1'b0 : (tx_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
      bus.proc_m_ready    = m_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.proc_s_valid    = 1'b0;
      bus.proc_s_data     = '0;
      if (!rst_n) begin
        resp_active = 1'b0;
        eng_q.delete();
      end else if (resp_active) begin
        if (resp_wait == 0) begin
          bus.proc_s_valid = 1'b1;
          bus.proc_s_data  = resp_data;
          resp_active = 1'b0;
        end else begin
          resp_wait--;
        end
      end else if (eng_q.size() > 0) begin
        eng_req = eng_q.pop_front();
        if (plan_q.size() > 0) eng_plan = plan_q.pop_front();
        else eng_plan = '{1'b1, 3};
        if (eng_plan.respond) begin
          resp_active = 1'b1;
          resp_wait   = eng_plan.lat - 1;
          resp_data   = ~eng_req.data;
        end
      end
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] s, input logic last, output int c);
    @(posedge clk);
    #1;
    bus.rx_axis_s_valid = 1'b1;
    bus.rx_axis_s_data  = {8'b0, s};
    bus.rx_axis_s_last  = last;
    c = cyc;
    @(posedge clk);
    #1;
    bus.rx_axis_s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    int c;
    send_beat(l, 1'b0, c);
    send_beat(r, 1'b1, c);
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int t = 0;
    while (fd_cnt < target && t < budget) begin
      settle();
      t++;
    end
    check_value({tag, "_frames"}, fd_cnt, target);
  endtask

  task automatic expect_tx(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input string tag);
    beat_t b;
    if (tx_q.size() < 2) begin
      check_value({tag, "_beats"}, tx_q.size(), 2);
    end else begin
      b = tx_q.pop_front();
      check_value({tag, "_l_data"}, b.data, {8'b0, l});
      check_value({tag, "_l_last"}, b.last, 0);
      b = tx_q.pop_front();
      check_value({tag, "_r_data"}, b.data, {8'b0, r});
      check_value({tag, "_r_last"}, b.last, 1);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_value({tag, "_ctrl"}, {25'b0, bus.rx_axis_s_ready, bus.tx_axis_m_valid, bus.tx_axis_m_last,
                                 bus.proc_m_valid, bus.proc_m_chan, bus.proc_s_ready, frame_done}, 0);
    check_value({tag, "_cnts"}, {overrun_cnt, timeout_cnt}, 0);
    check_value({tag, "_data"}, bus.tx_axis_m_data | {8'b0, bus.proc_m_data}, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base, c0, rand_to, t;
  logic [DATA_W-1:0] l, r;
  bit byp, rl, rr;

  initial begin
    bus.rx_axis_s_valid = 1'b0;
    bus.rx_axis_s_data  = '0;
    bus.rx_axis_s_last  = 1'b0;
    repeat (3) @(posedge clk);
    settle();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    settle();
    check_value("rx_ready_after_reset", bus.rx_axis_s_ready, 1);
    check_value("proc_s_ready_after_reset", bus.proc_s_ready, 1);

    // 1: bypass frame and launch latency
    bypass = 1'b1;
    base = fd_cnt;
    send_beat(24'h123456, 1'b0, c0);
    send_beat(24'hABCDEF, 1'b1, c0);
    wait_frames(base + 1, 100, "t1");
    check_value("t1_latency", rise_cyc - c0, 3);
    expect_tx(24'h123456, 24'hABCDEF, "t1");
    repeat (5) settle();
    check_value("t1_frame_done_once", fd_cnt - base, 1);
    check_value("t1_no_engine_req", req_log.size(), 0);

    // 2: processed frame through the invert engine
    bypass = 1'b0;
    req_log.delete();
    plan_q.push_back('{1'b1, 3});
    plan_q.push_back('{1'b1, 3});
    base = fd_cnt;
    send_frame(24'h000001, 24'h7FFFFF);
    wait_frames(base + 1, 200, "t2");
    expect_tx(24'hFFFFFE, 24'h800000, "t2");
    check_value("t2_req_count", req_log.size(), 2);
    if (req_log.size() == 2) begin
      check_value("t2_req0", {req_log[0].chan, req_log[0].data}, {1'b0, 24'h000001});
      check_value("t2_req1", {req_log[1].chan, req_log[1].data}, {1'b1, 24'h7FFFFF});
    end

    // 3: engine silent on both channels
    plan_q.push_back('{1'b0, 0});
    plan_q.push_back('{1'b0, 0});
    base = fd_cnt;
    send_frame(24'h0A0B0C, 24'h0D0E0F);
    wait_frames(base + 1, 3 * TIMEOUT, "t3");
    expect_tx(24'h0A0B0C, 24'h0D0E0F, "t3");
    check_value("t3_timeout_cnt", timeout_cnt, 2);

    // 5: misaligned R discarded
    bypass = 1'b1;
    base = fd_cnt;
    send_beat(24'h000055, 1'b1, c0);
    send_frame(24'h000010, 24'h000020);
    wait_frames(base + 1, 100, "t5");
    expect_tx(24'h000010, 24'h000020, "t5");
    repeat (10) settle();
    check_value("t5_no_extra_beats", tx_q.size(), 0);

    // 4: sink stalled while frames pile up
    tx_hold = 1'b1;
    base = fd_cnt;
    send_frame(24'hA0A0A1, 24'hA0A0A2);
    send_frame(24'hB0B0B1, 24'hB0B0B2);
    send_frame(24'hC0C0C1, 24'hC0C0C2);
    send_frame(24'hD0D0D1, 24'hD0D0D2);
    repeat (4) settle();
    check_value("t4_overrun_cnt", overrun_cnt, 2);
    tx_hold = 1'b0;
    wait_frames(base + 2, 100, "t4");
    expect_tx(24'hA0A0A1, 24'hA0A0A2, "t4_first");
    expect_tx(24'hB0B0B1, 24'hB0B0B2, "t4_buffered");
    repeat (10) settle();
    check_value("t4_no_extra_beats", tx_q.size(), 0);

    // Randomized frames with stalls, stray beats, random latencies and timeouts
    tx_rand = 1'b1;
    m_rand  = 1'b1;
    rand_to = 0;
    for (int i = 0; i < 30; i++) begin
      byp = 1'($urandom_range(0, 1));
      bypass = byp;
      l = DATA_W'($urandom);
      r = DATA_W'($urandom);
      rl = ($urandom_range(0, 7) != 0);
      rr = ($urandom_range(0, 7) != 0);
      if (!byp) begin
        plan_q.push_back('{rl, int'($urandom_range(1, 12))});
        plan_q.push_back('{rr, int'($urandom_range(1, 12))});
        rand_to += (rl ? 0 : 1) + (rr ? 0 : 1);
      end
      if ($urandom_range(0, 3) == 0) send_beat(DATA_W'($urandom), 1'b1, c0);
      if ($urandom_range(0, 3) == 0) send_beat(DATA_W'($urandom), 1'b0, c0);
      base = fd_cnt;
      send_frame(l, r);
      wait_frames(base + 1, 3 * TIMEOUT, "rand");
      expect_tx(ref_sample(l, byp, rl), ref_sample(r, byp, rr), "rand");
    end
    check_value("rand_timeout_cnt", timeout_cnt, 2 + rand_to);
    check_value("rand_overrun_cnt", overrun_cnt, 2);

    // 6: asynchronous reset while waiting on the R result
    tx_rand = 1'b0;
    m_rand  = 1'b0;
    bypass  = 1'b0;
    req_log.delete();
    plan_q.delete();
    plan_q.push_back('{1'b0, 0});
    plan_q.push_back('{1'b0, 0});
    send_frame(24'h333333, 24'h444444);
    t = 0;
    while (req_log.size() < 2 && t < 3 * TIMEOUT) begin
      settle();
      t++;
    end
    check_value("t6_reached_wait_r", req_log.size(), 2);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_async_reset");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tx_q.delete();
    plan_q.delete();
    repeat (2) @(posedge clk);
    base = fd_cnt;
    send_frame(24'h111111, 24'h222222);
    wait_frames(base + 1, 200, "t6");
    expect_tx(24'hEEEEEE, 24'hDDDDDD, "t6");
    check_value("t6_counters", {overrun_cnt, timeout_cnt}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
